slv_bar_router: RTL and testbench

Parametrised slave-bus back end behind pcie_tlp's slv_* interface. Decodes up to NUM_BAR BARs. BAR0 is an internal register file holding RW control registers, read-only status, W1C event bits, a snapshot cycle counter and an ID word. BAR1..NUM_BAR-1 are routed to external synchronous memories. Read data from every target returns at a common fixed latency with a valid strobe.

---
 rtl/slv_bus_pkg.sv | 39 +++
 rtl/slv_regfile.sv | 86 ++++++++
 rtl/slv_bar_router.sv | 145 ++++++++++++++
 tb/tb_slv_bar_router.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slv_bus_pkg.sv
// +----------------------------------------------------------------------------
// | slv_bus_pkg : shared widths, BAR0 word map and target-select type
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package slv_bus_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 2;

    localparam logic [5:0] IDX_STAT   = 6'd16;
    localparam logic [5:0] IDX_EVT    = 6'd24;
    localparam logic [5:0] IDX_CNT_LO = 6'd25;
    localparam logic [5:0] IDX_CNT_HI = 6'd26;
    localparam logic [5:0] IDX_ID     = 6'd31;

    typedef struct packed {
        logic       hit;
        logic [2:0] bar;
    } tgt_sel_t;

    // Lowest set bit wins when several BAR hits are asserted together.
    function automatic tgt_sel_t decode_bar(input logic [6:0] hits);
        tgt_sel_t t;
        t.hit = 1'b0;
        t.bar = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (hits[i]) begin
                t.hit = 1'b1;
                t.bar = 3'(i);
            end
        end
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/slv_regfile.sv
// +----------------------------------------------------------------------------
// | slv_regfile : BAR0 control/status/event/counter registers, 1-cycle read
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module slv_regfile
    import slv_bus_pkg::*;
#(
    parameter int                REG_COUNT  = 4,
    parameter int                STAT_COUNT = 2,
    parameter logic [DATA_W-1:0] ID_VALUE   = 16'h8010
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                wr_en,
    input  logic                                                rd_en,
    input  logic [5:0]                                          idx,
    input  logic [DATA_W-1:0]                                   wdat,
    input  logic [SEL_W-1:0]                                    sel,
    input  logic [((STAT_COUNT > 0) ? STAT_COUNT : 1)*DATA_W-1:0] stat,
    input  logic [DATA_W-1:0]                                   evt_in,
    output logic [DATA_W-1:0]                                   rdata,
    output logic [REG_COUNT*DATA_W-1:0]                         reg_q,
    output logic [REG_COUNT-1:0]                                reg_wr
);

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [DATA_W-1:0] evt_q;
    logic [DATA_W-1:0] evt_clr;
    logic [DATA_W-1:0] byte_mask;
    logic [DATA_W-1:0] rd_mux;
    logic [31:0]       counter;
    logic [15:0]       snap_hi;

    assign byte_mask = {{8{sel[1]}}, {8{sel[0]}}};
    assign evt_clr   = (wr_en && idx == IDX_EVT) ? (wdat & byte_mask) : '0;

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_reg_q
        assign reg_q[k*DATA_W +: DATA_W] = regs[k];
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < REG_COUNT; k++) begin
            if (idx == 6'(k)) rd_mux = regs[k];
        end
        for (int s = 0; s < STAT_COUNT; s++) begin
            if (idx == IDX_STAT + 6'(s)) rd_mux = stat[s*DATA_W +: DATA_W];
        end
        case (idx)
            IDX_EVT:    rd_mux = evt_q;
            IDX_CNT_LO: rd_mux = counter[15:0];
            IDX_CNT_HI: rd_mux = snap_hi;
            IDX_ID:     rd_mux = ID_VALUE;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
            reg_wr  <= '0;
            evt_q   <= '0;
            counter <= '0;
            snap_hi <= '0;
            rdata   <= '0;
        end else begin
            reg_wr <= '0;
            for (int k = 0; k < REG_COUNT; k++) begin
                if (wr_en && idx == 6'(k)) begin
                    regs[k]   <= (regs[k] & ~byte_mask) | (wdat & byte_mask);
                    reg_wr[k] <= 1'b1;
                end
            end
            // New events are ORed in after the clear so a coincident set survives.
            evt_q   <= (evt_q & ~evt_clr) | evt_in;
            counter <= counter + 32'd1;
            if (rd_en && idx == IDX_CNT_LO) snap_hi <= counter[31:16];
            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule

`default_nettype wire

// File: rtl/slv_bar_router.sv
// +----------------------------------------------------------------------------
// | slv_bar_router : BAR decode, memory routing and fixed-latency read return
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module slv_bar_router
    import slv_bus_pkg::*;
#(
    parameter int          NUM_BAR    = 3,
    parameter int          REG_COUNT  = 4,
    parameter int          STAT_COUNT = 2,
    parameter int          MEM_AW     = 14,
    parameter int          MEM_LAT    = 1,
    parameter logic [15:0] ID_VALUE   = 16'h8010
) (
    input  logic                                                pcie_clk,
    input  logic                                                sys_rst,
    input  logic [NUM_BAR-1:0]                                  slv_bar_i,
    input  logic                                                slv_ce_i,
    input  logic                                                slv_we_i,
    input  logic [19:1]                                         slv_adr_i,
    input  logic [DATA_W-1:0]                                   slv_dat_i,
    input  logic [SEL_W-1:0]                                    slv_sel_i,
    output logic [DATA_W-1:0]                                   slv_dat_o,
    output logic                                                slv_rd_vld_o,
    output logic [REG_COUNT*DATA_W-1:0]                         reg_q_o,
    output logic [REG_COUNT-1:0]                                reg_wr_o,
    input  logic [((STAT_COUNT > 0) ? STAT_COUNT : 1)*DATA_W-1:0] stat_i,
    input  logic [DATA_W-1:0]                                   evt_i,
    output logic [NUM_BAR-2:0]                                  mem_ce_o,
    output logic                                                mem_we_o,
    output logic [SEL_W-1:0]                                    mem_sel_o,
    output logic [MEM_AW-1:0]                                   mem_adr_o,
    output logic [DATA_W-1:0]                                   mem_dat_o,
    input  logic [(NUM_BAR-1)*DATA_W-1:0]                       mem_q_i
);

    tgt_sel_t          tgt;
    tgt_sel_t          sel_pipe [MEM_LAT];
    tgt_sel_t          out_sel;
    logic [MEM_LAT-1:0] vld_pipe;
    logic              rd_req;
    logic              bar0_wr;
    logic              bar0_rd;
    logic [DATA_W-1:0] reg_rdata;
    logic [DATA_W-1:0] bar0_dat;
    logic [DATA_W-1:0] mux_dat;
    logic [DATA_W-1:0] held_dat;
    logic              adr_unused;

    assign tgt     = decode_bar(7'(slv_bar_i));
    assign rd_req  = slv_ce_i & ~slv_we_i;
    assign bar0_wr = slv_ce_i & slv_we_i & tgt.hit & (tgt.bar == 3'd0);
    assign bar0_rd = rd_req & tgt.hit & (tgt.bar == 3'd0);

    // Memories see the raw bus; only the clock enable is BAR-qualified.
    for (genvar j = 0; j < NUM_BAR - 1; j++) begin : g_mem_ce
        assign mem_ce_o[j] = slv_ce_i & tgt.hit & (tgt.bar == 3'(j + 1));
    end

    assign mem_we_o   = slv_we_i;
    assign mem_sel_o  = slv_sel_i;
    assign mem_adr_o  = slv_adr_i[MEM_AW:1];
    assign mem_dat_o  = slv_dat_i;
    assign adr_unused = ^slv_adr_i;

    slv_regfile #(
        .REG_COUNT  (REG_COUNT),
        .STAT_COUNT (STAT_COUNT),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk    (pcie_clk),
        .rst    (sys_rst),
        .wr_en  (bar0_wr),
        .rd_en  (bar0_rd),
        .idx    (slv_adr_i[6:1]),
        .wdat   (slv_dat_i),
        .sel    (slv_sel_i),
        .stat   (stat_i),
        .evt_in (evt_i),
        .rdata  (reg_rdata),
        .reg_q  (reg_q_o),
        .reg_wr (reg_wr_o)
    );

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < MEM_LAT; i++) sel_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_req;
            sel_pipe[0] <= tgt;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sel_pipe[i] <= sel_pipe[i-1];
            end
        end
    end

    if (MEM_LAT > 1) begin : g_bar0_dly
        logic [DATA_W-1:0] dly [MEM_LAT-1];
        always_ff @(posedge pcie_clk) begin
            if (sys_rst) begin
                for (int i = 0; i < MEM_LAT - 1; i++) dly[i] <= '0;
            end else begin
                dly[0] <= reg_rdata;
                for (int i = 1; i < MEM_LAT - 1; i++) dly[i] <= dly[i-1];
            end
        end
        assign bar0_dat = dly[MEM_LAT-2];
    end else begin : g_bar0_direct
        assign bar0_dat = reg_rdata;
    end

    assign out_sel = sel_pipe[MEM_LAT-1];

    always_comb begin
        mux_dat = '0;
        if (out_sel.hit) begin
            if (out_sel.bar == 3'd0) begin
                mux_dat = bar0_dat;
            end else begin
                for (int j = 0; j < NUM_BAR - 1; j++) begin
                    if (out_sel.bar == 3'(j + 1)) mux_dat = mem_q_i[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Memory data is only present in the return cycle, so the hold value is registered.
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            held_dat <= '0;
        end else if (vld_pipe[MEM_LAT-1]) begin
            held_dat <= mux_dat;
        end
    end

    assign slv_rd_vld_o = vld_pipe[MEM_LAT-1];
    assign slv_dat_o    = vld_pipe[MEM_LAT-1] ? mux_dat : held_dat;

endmodule

`default_nettype wire

// File: tb/tb_slv_bar_router.sv
// +----------------------------------------------------------------------------
// | tb_slv_bar_router : randomized bench with a transaction-level reference model
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_slv_bar_router;

    localparam int NUM_BAR    = 3;
    localparam int REG_COUNT  = 4;
    localparam int STAT_COUNT = 2;
    localparam int MEM_AW     = 14;
    localparam int MEM_LAT    = 2;

    logic        pcie_clk = 1'b0;
    logic        sys_rst  = 1'b1;
    logic [2:0]  slv_bar_i = '0;
    logic        slv_ce_i  = 1'b0;
    logic        slv_we_i  = 1'b0;
    logic [19:1] slv_adr_i = '0;
    logic [15:0] slv_dat_i = '0;
    logic [1:0]  slv_sel_i = '0;
    logic [15:0] slv_dat_o;
    logic        slv_rd_vld_o;
    logic [63:0] reg_q_o;
    logic [3:0]  reg_wr_o;
    logic [31:0] stat_i = '0;
    logic [15:0] evt_i  = '0;
    logic [1:0]  mem_ce_o;
    logic        mem_we_o;
    logic [1:0]  mem_sel_o;
    logic [13:0] mem_adr_o;
    logic [15:0] mem_dat_o;
    logic [31:0] mem_q_i;

    slv_bar_router #(
        .NUM_BAR    (NUM_BAR),
        .REG_COUNT  (REG_COUNT),
        .STAT_COUNT (STAT_COUNT),
        .MEM_AW     (MEM_AW),
        .MEM_LAT    (MEM_LAT),
        .ID_VALUE   (16'h8010)
    ) u_dut (
        .pcie_clk     (pcie_clk),
        .sys_rst      (sys_rst),
        .slv_bar_i    (slv_bar_i),
        .slv_ce_i     (slv_ce_i),
        .slv_we_i     (slv_we_i),
        .slv_adr_i    (slv_adr_i),
        .slv_dat_i    (slv_dat_i),
        .slv_sel_i    (slv_sel_i),
        .slv_dat_o    (slv_dat_o),
        .slv_rd_vld_o (slv_rd_vld_o),
        .reg_q_o      (reg_q_o),
        .reg_wr_o     (reg_wr_o),
        .stat_i       (stat_i),
        .evt_i        (evt_i),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_sel_o    (mem_sel_o),
        .mem_adr_o    (mem_adr_o),
        .mem_dat_o    (mem_dat_o),
        .mem_q_i      (mem_q_i)
    );

    always #5 pcie_clk = ~pcie_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // External synchronous memories: MEM_LAT = 2 read pipeline per BAR
    logic [15:0] env_mem [2][16384];
    logic [15:0] st1 [2];
    logic [15:0] st2 [2];

    always @(posedge pcie_clk) begin
        for (int j = 0; j < 2; j++) begin
            if (mem_ce_o[j]) begin
                if (mem_we_o) begin
                    if (mem_sel_o[0]) env_mem[j][mem_adr_o][7:0]  <= mem_dat_o[7:0];
                    if (mem_sel_o[1]) env_mem[j][mem_adr_o][15:8] <= mem_dat_o[15:8];
                end else begin
                    st1[j] <= env_mem[j][mem_adr_o];
                end
            end
            st2[j] <= st1[j];
        end
    end

    assign mem_q_i = {st2[1], st2[0]};

    // Reference model state
    logic [63:0]  m_regq = '0;
    logic [15:0]  m_evt  = '0;
    logic [31:0]  m_snap = '0;
    logic [15:0]  shadow [2][16384];
    logic [31:0]  cyc = '0;
    int unsigned  tick = 0;
    logic [3:0]   cur_regwr = '0;
    logic [63:0]  exp_regq = '0;
    logic [3:0]   exp_regwr = '0;
    logic         rst_seen = 1'b0;
    logic         mon_en = 1'b0;
    logic [15:0]  last_dat = '0;
    logic         exp_v;

    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } rd_t;
    rd_t rq [$];

    always @(posedge pcie_clk) begin
        tick      <= tick + 1;
        rst_seen  <= sys_rst;
        cyc       <= sys_rst ? 32'd0 : cyc + 32'd1;
        exp_regq  <= sys_rst ? 64'd0 : m_regq;
        exp_regwr <= sys_rst ? 4'd0 : cur_regwr;
    end

    always @(negedge pcie_clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                rq.delete();
                last_dat = '0;
            end
            exp_v = (rq.size() > 0) && (rq[0].due == tick);
            check("rd_vld", 64'(slv_rd_vld_o), 64'(exp_v));
            if (exp_v) begin
                check("rd_dat", 64'(slv_dat_o), 64'(rq[0].data));
                last_dat = rq[0].data;
                void'(rq.pop_front());
            end else begin
                check("dat_hold", 64'(slv_dat_o), 64'(last_dat));
            end
            while (rq.size() > 0 && rq[0].due < tick) void'(rq.pop_front());
            check("reg_q", reg_q_o, exp_regq);
            check("reg_wr", 64'(reg_wr_o), 64'(exp_regwr));
        end
    end

    function automatic int lowest(input logic [2:0] bar);
        int idx = -1;
        for (int i = 2; i >= 0; i--) if (bar[i]) idx = i;
        return idx;
    endfunction

    function automatic logic [19:1] mk_adr(input int w);
        logic [19:1] a = '0;
        a[6:1] = 6'(w);
        return a;
    endfunction

    // One bus cycle: drive, predict, then check the combinational memory routing
    task automatic do_cycle(input logic [2:0] bar, input logic ce, input logic we,
                            input logic [19:1] adr, input logic [15:0] dat,
                            input logic [1:0] sel, input logic [15:0] evt);
        int          idx;
        int          w;
        int          a;
        logic [15:0] rd;
        logic [15:0] bm;
        logic [15:0] clr;
        logic [1:0]  exp_ce;
        @(posedge pcie_clk);
        #1;
        slv_bar_i = bar; slv_ce_i = ce; slv_we_i = we; slv_adr_i = adr;
        slv_dat_i = dat; slv_sel_i = sel; evt_i = evt;
        stat_i    = $urandom;
        idx = lowest(bar);
        w   = int'(adr[6:1]);
        a   = int'(adr[14:1]);
        bm  = {{8{sel[1]}}, {8{sel[0]}}};
        clr = '0;
        cur_regwr = '0;
        if (ce && !we) begin
            rd = '0;
            if (idx == 0) begin
                if (w < REG_COUNT)                            rd = m_regq[16*w +: 16];
                else if (w >= 16 && w < 16 + STAT_COUNT)      rd = stat_i[16*(w-16) +: 16];
                else if (w == 24)                             rd = m_evt;
                else if (w == 25) begin                       rd = cyc[15:0]; m_snap = cyc; end
                else if (w == 26)                             rd = m_snap[31:16];
                else if (w == 31)                             rd = 16'h8010;
            end else if (idx > 0) begin
                rd = shadow[idx-1][a];
            end
            rq.push_back('{tick + MEM_LAT, rd});
        end
        if (ce && we) begin
            if (idx == 0 && w < REG_COUNT) begin
                m_regq[16*w +: 16] = (m_regq[16*w +: 16] & ~bm) | (dat & bm);
                cur_regwr[w] = 1'b1;
            end
            if (idx == 0 && w == 24) clr = dat & bm;
            if (idx > 0) shadow[idx-1][a] = (shadow[idx-1][a] & ~bm) | (dat & bm);
        end
        m_evt = (m_evt & ~clr) | evt;
        @(negedge pcie_clk);
        exp_ce = (ce && idx > 0) ? 2'(1 << (idx - 1)) : 2'b00;
        check("mem_ce", 64'(mem_ce_o), 64'(exp_ce));
        if (exp_ce != 2'b00) begin
            check("mem_adr", 64'(mem_adr_o), 64'(adr[14:1]));
            check("mem_we",  64'(mem_we_o),  64'(we));
            check("mem_dat", 64'(mem_dat_o), 64'(dat));
            check("mem_sel", 64'(mem_sel_o), 64'(sel));
        end
    endtask

    task automatic idle();
        do_cycle(3'b000, 1'b0, 1'b0, '0, '0, 2'b00, '0);
    endtask

    task automatic rst_pulse();
        @(posedge pcie_clk);
        #1;
        sys_rst = 1'b1; slv_ce_i = 1'b0; evt_i = '0;
        m_regq = '0; m_evt = '0; m_snap = '0; cur_regwr = '0;
        @(posedge pcie_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge pcie_clk);
    endtask

    int picks [15] = '{0, 1, 2, 3, 4, 15, 16, 17, 18, 24, 25, 26, 27, 31, 63};

    initial begin
        #950000;
        $display("FAIL timeout: simulation exceeded its cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  bar;
        logic [19:1] a;
        int          r;
        int          guard;

        repeat (3) @(posedge pcie_clk);
        #1;
        sys_rst = 1'b0;
        mon_en  = 1'b1;
        @(negedge pcie_clk);
        check("rst_reg_q", reg_q_o, 64'd0);
        check("rst_reg_wr", 64'(reg_wr_o), 64'd0);
        check("rst_vld", 64'(slv_rd_vld_o), 64'd0);
        check("rst_dat", 64'(slv_dat_o), 64'd0);

        // ID read, byte-enable register writes
        do_cycle(3'b001, 1, 0, mk_adr(31), '0, 2'b11, '0);
        do_cycle(3'b001, 1, 1, mk_adr(1), 16'hABCD, 2'b01, '0);
        idle();
        do_cycle(3'b001, 1, 1, mk_adr(1), 16'hABCD, 2'b10, '0);
        do_cycle(3'b001, 1, 0, mk_adr(1), '0, 2'b11, '0);

        // Sticky events, W1C, set-beats-clear
        do_cycle(3'b000, 0, 0, '0, '0, 2'b00, 16'h0005);
        do_cycle(3'b001, 1, 1, mk_adr(24), 16'h0001, 2'b11, '0);
        do_cycle(3'b001, 1, 0, mk_adr(24), '0, 2'b11, '0);
        do_cycle(3'b001, 1, 1, mk_adr(24), 16'h0004, 2'b11, 16'h0004);
        do_cycle(3'b001, 1, 0, mk_adr(24), '0, 2'b11, '0);

        // Fill the memory working set so every later read has defined data
        for (int j = 1; j <= 2; j++) begin
            for (int w = 0; w < 32; w++) begin
                do_cycle(3'(1 << j), 1, 1, mk_adr(w), 16'($urandom), 2'b11, '0);
            end
        end

        // Multi-hit BAR routes to the lowest, then interleaved reads per cycle
        do_cycle(3'b110, 1, 1, mk_adr(16), 16'h5A3C, 2'b11, '0);
        do_cycle(3'b010, 1, 0, mk_adr(16), '0, 2'b11, '0);
        do_cycle(3'b001, 1, 0, mk_adr(31), '0, 2'b11, '0);
        do_cycle(3'b010, 1, 0, mk_adr(16), '0, 2'b11, '0);
        do_cycle(3'b100, 1, 0, mk_adr(7), '0, 2'b11, '0);
        do_cycle(3'b000, 1, 0, mk_adr(31), '0, 2'b11, '0);
        repeat (3) idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      bar = 3'b001;
            else if (r <= 5) bar = 3'b010;
            else if (r <= 7) bar = 3'b100;
            else if (r == 8) bar = 3'b000;
            else             bar = 3'($urandom);
            a = 19'($urandom);
            if (lowest(bar) == 0) a[6:1] = 6'(picks[$urandom_range(0, 14)]);
            else                  a[14:6] = '0;
            do_cycle(bar, ($urandom_range(0, 9) != 0), 1'($urandom), a, 16'($urandom),
                     2'($urandom), ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000);
        end
        repeat (3) idle();

        // Snapshot: read low half as it wraps, then the frozen high half later
        guard = 0;
        while (cyc != 32'h0000_FFFE && guard < 70000) begin
            idle();
            guard++;
        end
        if (guard >= 70000) check("cnt_wait_timeout", 64'(cyc), 64'h0000_FFFE);
        do_cycle(3'b001, 1, 0, mk_adr(25), '0, 2'b11, '0);
        idle();
        idle();
        do_cycle(3'b001, 1, 0, mk_adr(26), '0, 2'b11, '0);
        repeat (3) idle();

        // Reset one cycle after a read: the pending read must vanish
        do_cycle(3'b001, 1, 0, mk_adr(31), '0, 2'b11, '0);
        rst_pulse();
        repeat (2) idle();
        do_cycle(3'b001, 1, 0, mk_adr(31), '0, 2'b11, '0);
        repeat (4) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
